// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse digit encoder: FSM states and the
// digit-to-code table (bit 4 = first symbol, 1 = dash).
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int NUM_SYMS   = 5;
  localparam int NUM_DIGITS = 10;

  localparam logic [NUM_SYMS-1:0] DIGIT_CODE [0:NUM_DIGITS-1] = '{
    5'b11111,  // 0
    5'b01111,  // 1
    5'b00111,  // 2
    5'b00011,  // 3
    5'b00001,  // 4
    5'b00000,  // 5
    5'b10000,  // 6
    5'b11000,  // 7
    5'b11100,  // 8
    5'b11110   // 9
  };

endpackage

// File: rtl/morse_digit_lut.sv
// Combinational BCD-digit to 5-symbol Morse code lookup with a legality flag
// for codes 10..15.
module morse_digit_lut
  import morse_pkg::*;
(
  input  logic [3:0]          i_digit,
  output logic [NUM_SYMS-1:0] o_code,
  output logic                o_legal
);

  always_comb begin
    o_code  = '0;
    o_legal = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_digit == 4'(i)) begin
        o_code  = DIGIT_CODE[i];
        o_legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_m.sv
// Morse digit encoder: captures a BCD digit, presents its code on m1..m5 and
// keys it out serially on sym_out with dot/dash/gap timing.
module morse_m
  import morse_pkg::*;
#(
  parameter int DOT_LEN  = 1,
  parameter int DASH_LEN = 3,
  parameter int GAP_LEN  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic ready,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic m1,
  output logic m2,
  output logic m3,
  output logic m4,
  output logic m5,
  output logic valid,
  output logic err,
  output logic busy,
  output logic sym_out
);

  localparam int MAX_LEN = (DASH_LEN > GAP_LEN) ? DASH_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(DOT_LEN - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [2:0]       K_LAST    = 3'(NUM_SYMS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [3:0]          w_digit;
  logic [NUM_SYMS-1:0] w_code;
  logic                w_legal;
  logic                w_cap;
  logic [NUM_SYMS-1:0] w_shift;
  logic                w_cur_dash;
  logic [CNT_W-1:0]    w_mark_last;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [2:0]          r_k;
  logic [2:0]          w_k_next;

  logic [NUM_SYMS-1:0] r_code;
  logic                r_valid;
  logic                r_err;
  logic                r_busy;
  logic                r_sym;

  assign w_digit = {a, b, c, d};

  morse_digit_lut u_lut (
    .i_digit (w_digit),
    .o_code  (w_code),
    .o_legal (w_legal)
  );

  // A capture is only possible while no playback is in progress.
  assign w_cap = ready & ~r_busy;

  // Current symbol selected by shifting it into the MSB position.
  assign w_shift     = r_code << r_k;
  assign w_cur_dash  = w_shift[NUM_SYMS-1];
  assign w_mark_last = w_cur_dash ? DASH_LAST : DOT_LAST;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_k_next   = r_k;
    case (r_state)
      IDLE: begin
        if (w_cap && w_legal) begin
          w_next     = MARK;
          w_cnt_next = '0;
          w_k_next   = '0;
        end
      end
      MARK: begin
        if (r_cnt >= w_mark_last) begin
          w_next     = SPACE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = sat_inc(r_cnt);
        end
      end
      SPACE: begin
        if (r_cnt >= GAP_LAST) begin
          w_cnt_next = '0;
          if (r_k == K_LAST) begin
            w_next = IDLE;
          end else begin
            w_next   = MARK;
            w_k_next = r_k + 3'd1;
          end
        end else begin
          w_cnt_next = sat_inc(r_cnt);
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
        w_k_next   = '0;
      end
    endcase
  end

  // FSM, counters and the key/busy outputs, registered from the next state so
  // they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_sym   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_k     <= w_k_next;
      r_busy  <= (w_next != IDLE);
      r_sym   <= (w_next == MARK);
    end
  end

  // Capture registers; an illegal digit clears the code and pulses err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_cap) begin
      if (w_legal) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end else begin
        r_code  <= '0;
        r_valid <= 1'b0;
        r_err   <= 1'b1;
      end
    end else begin
      r_err <= 1'b0;
    end
  end

  assign {m1, m2, m3, m4, m5} = r_code;
  assign valid   = r_valid;
  assign err     = r_err;
  assign busy    = r_busy;
  assign sym_out = r_sym;

endmodule

// File: tb/tb_morse_m.sv
// Bench for morse_m: a queue-based playback model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_morse_m;

  localparam int DOT  = 1;
  localparam int DASH = 3;
  localparam int GAP  = 1;

  logic clock, reset, ready, a, b, c, d;
  logic m1, m2, m3, m4, m5, valid, err, busy, sym_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  morse_m #(.DOT_LEN(DOT), .DASH_LEN(DASH), .GAP_LEN(GAP)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .a(a), .b(b), .c(c), .d(d),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .valid(valid), .err(err), .busy(busy), .sym_out(sym_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Code from the digit rule: symbol i (1-based) is a dash when i > n for
  // 1..5, when i <= n-5 for 6..9, and always for 0. Bit 4 holds m1.
  function automatic logic [4:0] model_code(input int n);
    logic [4:0] cd;
    cd = '0;
    for (int i = 1; i <= 5; i++) begin
      if (n == 0)      cd[5-i] = 1'b1;
      else if (n <= 5) cd[5-i] = (i > n);
      else             cd[5-i] = (i <= n - 5);
    end
    return cd;
  endfunction

  // Reference model: the playback is a queue of key levels, one per cycle.
  bit         q[$];
  logic [4:0] e_m;
  logic       e_valid, e_err, e_busy, e_sym;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      e_m = '0; e_valid = 0; e_err = 0; e_busy = 0; e_sym = 0;
    end else begin
      int  n;
      bit  cap;
      n   = int'({a, b, c, d});
      cap = ready && !e_busy;
      e_err = 0;
      if (cap) begin
        if (n <= 9) begin
          e_m = model_code(n);
          e_valid = 1;
          for (int s = 4; s >= 0; s--) begin
            repeat (e_m[s] ? DASH : DOT) q.push_back(1'b1);
            repeat (GAP) q.push_back(1'b0);
          end
        end else begin
          e_m = '0; e_valid = 0; e_err = 1;
        end
      end
      if (q.size() != 0) begin
        e_busy = 1;
        e_sym  = q.pop_front();
      end else begin
        e_busy = 0;
        e_sym  = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en && !reset) begin
      chk("m_vec",   {27'd0, m1, m2, m3, m4, m5}, {27'd0, e_m});
      chk("valid",   32'(valid),   32'(e_valid));
      chk("err",     32'(err),     32'(e_err));
      chk("busy",    32'(busy),    32'(e_busy));
      chk("sym_out", 32'(sym_out), 32'(e_sym));
    end
  end

  task automatic set_digit(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy === 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", 32'(t < 200), 32'd1);
  endtask

  logic [4:0] sweep_exp [10];
  logic [17:0] seq;
  logic [17:0] seq_exp;
  int bcount;

  initial begin
    sweep_exp = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000,
                  5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    seq_exp = 18'b10_1110_1110_1110_1110;
    reset = 1; ready = 0; set_digit(4'd0);

    // Model pinned against hand-derived codes
    chk("model_code_1", 32'(model_code(1)), 32'(5'b01111));
    chk("model_code_6", 32'(model_code(6)), 32'(5'b10000));
    chk("model_code_0", 32'(model_code(0)), 32'(5'b11111));

    // Reset then idle
    repeat (2) @(negedge clock);
    reset = 0;
    check_en = 1;
    repeat (5) @(negedge clock);
    chk("rst_m",    32'({m1, m2, m3, m4, m5}), 32'd0);
    chk("rst_out",  32'({valid, err, busy, sym_out}), 32'd0);

    // Sweep digits 1..9, 0
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      ready = 1; set_digit(4'((i + 1) % 10));
      @(negedge clock);
      ready = 0;
      chk("sweep_m", 32'({m1, m2, m3, m4, m5}), 32'(sweep_exp[i]));
      chk("sweep_valid", 32'(valid), 32'd1);
    end
    wait_idle();

    // Illegal code 1010
    ready = 1; set_digit(4'b1010);
    @(negedge clock);
    ready = 0;
    chk("ill_err",   32'(err), 32'd1);
    chk("ill_valid", 32'(valid), 32'd0);
    chk("ill_m",     32'({m1, m2, m3, m4, m5}), 32'd0);
    chk("ill_busy",  32'(busy), 32'd0);
    @(negedge clock);
    chk("ill_err_drop", 32'(err), 32'd0);
    chk("ill_busy2",    32'(busy), 32'd0);

    // Serial timing of digit 1
    ready = 1; set_digit(4'd1);
    @(negedge clock);
    ready = 0;
    bcount = 0;
    for (int j = 0; j < 18; j++) begin
      seq[17 - j] = sym_out;
      if (busy) bcount++;
      @(negedge clock);
    end
    chk("ser_seq",   32'(seq), 32'(seq_exp));
    chk("ser_busy",  32'(bcount), 32'(5 * GAP + 1 * DOT + 4 * DASH));
    chk("ser_done",  32'(busy), 32'd0);

    // Capture attempt while busy
    ready = 1; set_digit(4'd9);
    @(negedge clock);
    ready = 0;
    repeat (3) @(negedge clock);
    ready = 1; set_digit(4'd2);
    repeat (2) @(negedge clock);
    ready = 0;
    chk("busy_cap_m", 32'({m1, m2, m3, m4, m5}), 32'(5'b11110));
    chk("busy_cap_err", 32'(err), 32'd0);
    wait_idle();
    chk("busy_cap_m_end", 32'({m1, m2, m3, m4, m5}), 32'(5'b11110));

    // Reset during the third symbol of digit 9
    ready = 1; set_digit(4'd9);
    @(negedge clock);
    ready = 0;
    repeat (8) @(posedge clock);
    #2;
    chk("mid_sym_pre",  32'(sym_out), 32'd1);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1;
    #1;
    chk("mid_rst_m",   32'({m1, m2, m3, m4, m5}), 32'd0);
    chk("mid_rst_out", 32'({valid, err, busy, sym_out}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    @(negedge clock);

    // Randomized phase
    for (int t = 0; t < 2500; t++) begin
      ready = ($urandom_range(0, 3) != 0);
      set_digit(4'($urandom_range(0, 15)));
      @(negedge clock);
    end
    ready = 0;
    wait_idle();
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
